// File: rtl/sift_pkg.sv
// rtl/sift_pkg.sv - shared types, record constants and width helpers for the SIFT blocks
package sift_pkg;

    typedef enum logic [1:0] {
        O1 = 2'd0,
        O2 = 2'd1,
        O3 = 2'd2
    } octave_t;

    typedef enum logic [2:0] {
        IDLE,
        KEY_WAIT,
        KEY_CHECK,
        DESC_WAIT,
        SEND,
        TERM,
        FINISH
    } state_t;

    localparam int RECORD_LEN = 10;
    localparam logic [7:0] TERM_BYTE = 8'hFF;

    // Histogram word width: 8 bits per subpatch-index bit of a patch.
    function automatic int desc_width(input int patch_size);
        return $clog2((patch_size / 2) * (patch_size / 2)) * 8;
    endfunction

    // Keypoint word width: {x, y, level}.
    function automatic int key_width(input int dimension);
        return 2 * $clog2(dimension) + 1;
    endfunction

endpackage

// File: rtl/descriptor_reader_if.sv
// rtl/descriptor_reader_if.sv - byte stream toward the UART transmitter
interface descriptor_reader_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/byte_tx_buffer.sv
// rtl/byte_tx_buffer.sv - one-entry holding register between the reader FSM and the byte stream
module byte_tx_buffer (
    input  logic                        clk,
    input  logic                        rst_in,
    input  logic [7:0]                  in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    descriptor_reader_if.master         tx
);

    // Accept a new byte when empty or when the held byte leaves this cycle.
    assign in_ready = !tx.tx_valid || tx.tx_ready;

    // Hold the byte steady until the consumer takes it.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            tx.tx_valid <= 1'b0;
            tx.tx_data  <= 8'h00;
        end else if (in_valid && in_ready) begin
            tx.tx_valid <= 1'b1;
            tx.tx_data  <= in_data;
        end else if (tx.tx_ready) begin
            tx.tx_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/descriptor_reader.sv
// rtl/descriptor_reader.sv - walks keypoint/descriptor BRAMs and streams 10-byte records plus a terminator
module descriptor_reader
    import sift_pkg::*;
#(
    parameter int DIMENSION    = 64,
    parameter int PATCH_SIZE   = 4,
    parameter int READ_LATENCY = 2,
    localparam int AW = $clog2(DIMENSION * DIMENSION),
    localparam int KW = key_width(DIMENSION),
    localparam int DW = desc_width(PATCH_SIZE)
) (
    input  logic                clk,
    input  logic                rst_in,
    input  logic                start,
    output logic [AW-1:0]       key_read_addr,
    input  logic [KW-1:0]       keypoint_read,
    output logic [AW-1:0]       desc_read_addr,
    input  logic [DW-1:0]       desc_read,
    descriptor_reader_if.master tx,
    output logic                done
);

    localparam int REC_W = RECORD_LEN * 8;
    localparam int CW = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);
    localparam logic [AW-1:0] ADDR_MAX = AW'(DIMENSION * DIMENSION - 1);

    state_t             state;
    octave_t            octave;
    logic [CW-1:0]      cnt;
    logic [1:0]         wcnt;
    logic [3:0]         idx;
    logic [REC_W-1:0]   rec;
    logic               in_valid;
    logic               in_ready;
    logic [7:0]         in_data;

    // Offer the head of the record (or the terminator) to the holding register.
    assign in_valid = (state == SEND) || (state == TERM);
    assign in_data  = (state == TERM) ? TERM_BYTE : rec[REC_W-1 -: 8];

    byte_tx_buffer u_buf (
        .clk      (clk),
        .rst_in   (rst_in),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .tx       (tx)
    );

    // Readout sequencer: keypoint fetch, descriptor gather, record emission.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state          <= IDLE;
            octave         <= O1;
            key_read_addr  <= '0;
            desc_read_addr <= '0;
            done           <= 1'b0;
            cnt            <= '0;
            wcnt           <= '0;
            idx            <= '0;
            rec            <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        key_read_addr  <= '0;
                        desc_read_addr <= '0;
                        octave         <= O1;
                        cnt            <= '0;
                        state          <= KEY_WAIT;
                    end
                end
                KEY_WAIT: begin
                    if (cnt == CW'(READ_LATENCY - 1)) state <= KEY_CHECK;
                    else cnt <= cnt + CW'(1);
                end
                KEY_CHECK: begin
                    cnt <= '0;
                    if (keypoint_read == '0) begin
                        // Octave separator: move past it, or finish after the last octave.
                        if (key_read_addr != ADDR_MAX) key_read_addr <= key_read_addr + AW'(1);
                        if (octave == O3 || key_read_addr == ADDR_MAX) begin
                            state <= TERM;
                        end else begin
                            octave <= (octave == O1) ? O2 : O3;
                            state  <= KEY_WAIT;
                        end
                    end else begin
                        rec   <= {octave, 1'b0, keypoint_read[KW-1:8], keypoint_read[7:0],
                                  {(REC_W-16){1'b0}}};
                        wcnt  <= '0;
                        idx   <= '0;
                        state <= DESC_WAIT;
                    end
                end
                DESC_WAIT: begin
                    if (cnt == CW'(READ_LATENCY)) begin
                        // Histogram words shift in behind the two key bytes, MSB byte first.
                        cnt              <= '0;
                        rec[REC_W-17:0]  <= {rec[REC_W-17-DW:0], desc_read};
                        if (desc_read_addr != ADDR_MAX) desc_read_addr <= desc_read_addr + AW'(1);
                        wcnt             <= wcnt + 2'd1;
                        if (wcnt == 2'd3) state <= SEND;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                SEND: begin
                    if (in_ready) begin
                        rec <= rec << 8;
                        idx <= idx + 4'd1;
                        if (idx == 4'(RECORD_LEN - 1)) begin
                            if (key_read_addr < ADDR_MAX) begin
                                key_read_addr <= key_read_addr + AW'(1);
                                cnt           <= '0;
                                state         <= KEY_WAIT;
                            end else begin
                                state <= TERM;
                            end
                        end
                    end
                end
                TERM: begin
                    if (in_ready) state <= FINISH;
                end
                FINISH: begin
                    // Signal completion only once the terminator has left the buffer.
                    if (!tx.tx_valid) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
